ahb_spi_slave: RTL and testbench



---
 rtl/ahb_spi_slave_pkg.sv | 22 ++
 rtl/spi_slave_sync_edge.sv | 32 +++
 rtl/ahb_spi_slave.sv | 152 +++++++++++++++
 tb/tb_ahb_spi_slave.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_spi_slave_pkg.sv
// Shared constants for the AHB SPI responder.
// Register offsets, bit positions and frame width.
package ahb_spi_slave_pkg;

  localparam int FRAME_W = 8;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TX     = 2'd1;
  localparam logic [1:0] REG_RX     = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int ST_RX_VALID  = 0;
  localparam int ST_OVERRUN   = 1;
  localparam int ST_TX_FULL   = 2;
  localparam int ST_BUSY      = 3;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [CNT_W-1:0]   cnt_t;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchronizer with a history flop
// producing single-cycle rise/fall pulses.
module spi_slave_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/ahb_spi_slave.sv
// AHB-Lite SPI mode-0 responder with TX holding
// register, RX register and overrun/IRQ status.
module ahb_spi_slave
  import ahb_spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        CS_N,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        MISO,
  output logic        IRQ
);

  logic [1:0] addr_q;
  logic       wr_q;
  logic       rd_q;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  cnt_t   bitcnt;
  frame_t rx_sh, tx_sh, hold, rx_data, rbyte;
  logic   tx_full, rx_valid, overrun, busy, irq_en;

  logic wr_ctrl, wr_tx, wr_st, rd_rx;
  logic rise_v, fall_v, byte_done, frame_end, reload;

  logic unused;
  assign unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0],
                    HWDATA[31:8], sclk_s};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else if (HREADY) begin
      addr_q <= HADDR[3:2];
      wr_q   <= HSEL & HWRITE & HTRANS[1];
      rd_q   <= HSEL & ~HWRITE & HTRANS[1];
    end
  end

  spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .HCLK(HCLK), .HRESETn(HRESETn), .din(SCLK),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_slave_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .HCLK(HCLK), .HRESETn(HRESETn), .din(CS_N),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) mosi_q <= '0;
    else          mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign wr_ctrl = wr_q && (addr_q == REG_CTRL);
  assign wr_tx   = wr_q && (addr_q == REG_TX);
  assign wr_st   = wr_q && (addr_q == REG_STATUS) && HWDATA[ST_OVERRUN];
  assign rd_rx   = rd_q && (addr_q == REG_RX);

  assign rise_v    = sclk_rise & ~cs_s & ~cs_fall;
  assign fall_v    = sclk_fall & ~cs_s & ~cs_fall;
  assign byte_done = rise_v && (bitcnt == cnt_t'(FRAME_W - 1));
  assign frame_end = fall_v && (bitcnt == cnt_t'(FRAME_W));
  assign reload    = cs_fall | frame_end;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bitcnt <= '0;
      busy   <= 1'b0;
      rx_sh  <= '0;
      tx_sh  <= '0;
    end else begin
      if (cs_rise) begin
        bitcnt <= '0;
        busy   <= 1'b0;
      end else if (cs_fall) begin
        bitcnt <= '0;
        busy   <= 1'b1;
      end else if (rise_v) begin
        bitcnt <= bitcnt + 1'b1;
      end else if (frame_end) begin
        bitcnt <= '0;
      end
      if (rise_v) rx_sh <= {rx_sh[FRAME_W-2:0], mosi_s};
      // reload uses the pre-write holding value
      if (reload)      tx_sh <= tx_full ? hold : '0;
      else if (fall_v) tx_sh <= {tx_sh[FRAME_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold     <= '0;
      tx_full  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= HWDATA[CTRL_IRQ_EN];
      if (wr_tx)   hold   <= HWDATA[FRAME_W-1:0];
      if (wr_tx)       tx_full <= 1'b1;
      else if (reload) tx_full <= 1'b0;
      if (byte_done) rx_data <= {rx_sh[FRAME_W-2:0], mosi_s};
      if (byte_done)  rx_valid <= 1'b1;
      else if (rd_rx) rx_valid <= 1'b0;
      if (byte_done && rx_valid && !rd_rx) overrun <= 1'b1;
      else if (wr_st)                      overrun <= 1'b0;
    end
  end

  always_comb begin
    rbyte = '0;
    if (rd_q) begin
      unique case (1'b1)
        addr_q == REG_CTRL: rbyte[CTRL_IRQ_EN] = irq_en;
        addr_q == REG_TX:   rbyte = hold;
        addr_q == REG_RX:   rbyte = rx_data;
        addr_q == REG_STATUS: begin
          rbyte[ST_RX_VALID] = rx_valid;
          rbyte[ST_OVERRUN]  = overrun;
          rbyte[ST_TX_FULL]  = tx_full;
          rbyte[ST_BUSY]     = busy;
        end
      endcase
    end
  end

  assign HRDATA    = {{(32-FRAME_W){1'b0}}, rbyte};
  assign HREADYOUT = 1'b1;
  assign MISO      = ~cs_s & tx_sh[FRAME_W-1];
  assign IRQ       = irq_en & rx_valid;

endmodule

// File: tb/tb_ahb_spi_slave.sv
// Self-checking bench for ahb_spi_slave: register table,
// directed SPI corner cases and a randomized frame-level model.
module tb_ahb_spi_slave;

  localparam int HP = 8;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        SCLK, MOSI, CS_N;
  logic        HREADYOUT, MISO, IRQ;

  int n_cmp = 0;
  int n_err = 0;

  ahb_spi_slave #(.SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HWRITE(HWRITE), .HADDR(HADDR), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .MISO(MISO), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [7:0]  d;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic ahb_wr(input logic [3:0] a, input logic [7:0] d);
    HSEL = 1; HWRITE = 1; HTRANS = 2'b10; HADDR = {28'h0, a};
    @(negedge HCLK);
    HSEL = 0; HWRITE = 0; HTRANS = 2'b00; HWDATA = {24'h0, d};
    @(negedge HCLK);
  endtask

  task automatic ahb_rd(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1; HWRITE = 0; HTRANS = 2'b10; HADDR = {28'h0, a};
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00;
    d = HRDATA;
    @(negedge HCLK);
  endtask

  task automatic cs_low();
    CS_N = 0;
    idle(HP);
  endtask

  task automatic cs_high();
    idle(HP);
    CS_N = 1;
    idle(HP);
  endtask

  // Master side of one frame; rd_hook issues an RXDATA read
  // timed to land on the same edge as the 8th-bit completion.
  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi,
                          input int nbits, input bit rd_hook);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      idle(HP);
      mi = {mi[6:0], MISO};
      SCLK = 1;
      if (rd_hook && i == 7) begin
        idle(1);
        HSEL = 1; HWRITE = 0; HTRANS = 2'b10; HADDR = 32'h8;
        idle(1);
        HSEL = 0; HTRANS = 2'b00;
        idle(HP - 2);
      end else begin
        idle(HP);
      end
      SCLK = 0;
    end
  endtask

  vec_t        tbl[12];
  logic [31:0] rd;
  logic [7:0]  mi;

  logic [7:0] m_hold, m_rx, mo, b;
  bit         m_full, m_rxv, m_ovr;

  initial begin
    HRESETn = 0; HSEL = 0; HREADY = 1; HWRITE = 0;
    HADDR = 0; HTRANS = 0; HWDATA = 0;
    SCLK = 0; MOSI = 0; CS_N = 1;
    idle(3);
    HRESETn = 1;
    idle(2);

    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_miso", {31'h0, MISO}, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);

    tbl[0]  = '{0, 4'h0, 8'h00, 32'h00};
    tbl[1]  = '{0, 4'h8, 8'h00, 32'h00};
    tbl[2]  = '{0, 4'hC, 8'h00, 32'h00};
    tbl[3]  = '{1, 4'h0, 8'hFF, 32'h00};
    tbl[4]  = '{0, 4'h0, 8'h00, 32'h01};
    tbl[5]  = '{1, 4'h0, 8'hFE, 32'h00};
    tbl[6]  = '{0, 4'h0, 8'h00, 32'h00};
    tbl[7]  = '{1, 4'h4, 8'h5A, 32'h00};
    tbl[8]  = '{0, 4'h4, 8'h00, 32'h5A};
    tbl[9]  = '{0, 4'hC, 8'h00, 32'h04};
    tbl[10] = '{1, 4'hC, 8'h02, 32'h00};
    tbl[11] = '{0, 4'hC, 8'h00, 32'h04};
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) ahb_wr(tbl[i].a, tbl[i].d);
      else begin
        ahb_rd(tbl[i].a, rd);
        check($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end
    end

    // reset in the middle of a frame
    cs_low();
    spi_byte(8'hF0, mi, 4, 0);
    HRESETn = 0;
    idle(2);
    check("midrst_miso", {31'h0, MISO}, 32'h0);
    check("midrst_irq", {31'h0, IRQ}, 32'h0);
    CS_N = 1; SCLK = 0;
    idle(2);
    HRESETn = 1;
    idle(4);
    ahb_rd(4'hC, rd); check("midrst_status", rd, 32'h00);
    cs_low();
    spi_byte(8'h96, mi, 8, 0);
    cs_high();
    ahb_rd(4'hC, rd); check("postrst_status", rd, 32'h01);
    ahb_rd(4'h8, rd); check("postrst_rx", rd, 32'h96);

    // TX A5 out, 3C in, IRQ path
    ahb_wr(4'h0, 8'h01);
    ahb_wr(4'h4, 8'hA5);
    cs_low();
    spi_byte(8'h3C, mi, 8, 0);
    cs_high();
    check("a5_miso", {24'h0, mi}, 32'hA5);
    check("a5_irq", {31'h0, IRQ}, 32'h1);
    ahb_rd(4'hC, rd); check("a5_status", rd, 32'h01);
    ahb_rd(4'h8, rd); check("a5_rx", rd, 32'h3C);
    idle(1);
    check("a5_irq_clr", {31'h0, IRQ}, 32'h0);

    // no TX load: zeros returned
    cs_low();
    spi_byte(8'hFF, mi, 8, 0);
    cs_high();
    check("ff_miso", {24'h0, mi}, 32'h00);
    ahb_rd(4'hC, rd); check("ff_status", rd, 32'h01);
    ahb_rd(4'h8, rd); check("ff_rx", rd, 32'hFF);

    // two frames under one CS_N, overrun
    cs_low();
    spi_byte(8'h11, mi, 8, 0);
    spi_byte(8'h22, mi, 8, 0);
    cs_high();
    ahb_rd(4'hC, rd); check("ovr_status", rd, 32'h03);
    ahb_rd(4'h8, rd); check("ovr_rx", rd, 32'h22);
    ahb_wr(4'hC, 8'h02);
    ahb_rd(4'hC, rd); check("ovr_clr", rd, 32'h00);

    // aborted frame after 5 bits
    cs_low();
    ahb_rd(4'hC, rd); check("busy", rd, 32'h08);
    spi_byte(8'hC3, mi, 5, 0);
    cs_high();
    ahb_rd(4'hC, rd); check("abort_status", rd, 32'h00);
    cs_low();
    spi_byte(8'h81, mi, 8, 0);
    cs_high();
    ahb_rd(4'hC, rd); check("abort_next_st", rd, 32'h01);
    ahb_rd(4'h8, rd); check("abort_next_rx", rd, 32'h81);

    // read coinciding with completion
    cs_low();
    spi_byte(8'h55, mi, 8, 0);
    spi_byte(8'h7E, mi, 8, 1);
    cs_high();
    ahb_rd(4'hC, rd); check("coinc_status", rd, 32'h01);
    ahb_rd(4'h8, rd); check("coinc_rx", rd, 32'h7E);

    // randomized frame-level model
    m_hold = 8'h00; m_full = 0; m_rxv = 0; m_ovr = 0; m_rx = 8'h7E;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          b = 8'($urandom);
          ahb_wr(4'h4, b);
          m_hold = b; m_full = 1;
        end
        1: begin
          int nf;
          nf = $urandom_range(1, 2);
          cs_low();
          for (int f = 0; f < nf; f++) begin
            mo = 8'($urandom);
            spi_byte(mo, mi, 8, 0);
            check("rnd_miso", {24'h0, mi},
                  {24'h0, m_full ? m_hold : 8'h00});
            m_full = 0;
            if (m_rxv) m_ovr = 1;
            m_rxv = 1;
            m_rx = mo;
          end
          cs_high();
        end
        2: begin
          check("rnd_irq", {31'h0, IRQ}, {31'h0, m_rxv});
          ahb_rd(4'h8, rd);
          check("rnd_rx", rd, {24'h0, m_rx});
          m_rxv = 0;
        end
        default: begin
          ahb_rd(4'hC, rd);
          check("rnd_status", rd,
                {29'h0, m_full, m_ovr, m_rxv});
          if ($urandom_range(0, 1) == 1) begin
            ahb_wr(4'hC, 8'h02);
            m_ovr = 0;
          end
        end
      endcase
    end
    ahb_rd(4'hC, rd);
    check("rnd_final", rd, {29'h0, m_full, m_ovr, m_rxv});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
